// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps each detection pulse from the 1011 sequence
// detector and buffers the timestamps in a small FIFO that a controller
// drains over a valid/ready handshake. Saturating hit and drop statistics and
// a sticky overflow flag are kept alongside the FIFO.
//
// Optional feature (macro SEQ_EVENT_LOGGER_GAP_EN): each entry also carries
// the number of cycles since the previous stored hit, presented on evt_gap.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   hit_i       detection pulse, sampled at the rising edge of clk
//   clr_i       synchronous clear of FIFO, statistics and overflow (not ts)
//   evt_valid   FIFO head entry available
//   evt_ready   consumer accepts the head entry
//   evt_ts      timestamp of the head entry, 0 when evt_valid=0
//   fifo_level  number of occupied FIFO entries (0..FIFO_DEPTH)
//   hit_count   hits since reset/clear, saturating
//   drop_count  hits lost to a full FIFO, saturating
//   overflow    sticky: at least one hit dropped since reset/clear
//   evt_gap     (SEQ_EVENT_LOGGER_GAP_EN only) gap of the head entry, 0 when empty
//
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally.

module seq_event_logger #(
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hit_i,
  input  logic                          clr_i,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_W-1:0]               evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          overflow
`ifdef SEQ_EVENT_LOGGER_GAP_EN
  ,
  output logic [TS_W-1:0]               evt_gap
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  // Free-running timestamp
  logic [TS_W-1:0] ts_q, ts_d;

  // FIFO storage and bookkeeping
  logic [TS_W-1:0]  mem_ts_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Statistics
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;

  logic fifo_full, fifo_empty;
  logic do_push, do_pop, do_drop, hit_live;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    hit_live   = hit_i & ~clr_i;
    // A pop needs a stored entry, so there is never a bypass from an empty FIFO.
    do_pop     = ~fifo_empty & evt_ready & ~clr_i;
    // A pop on the same edge frees the slot a full FIFO would otherwise lack.
    do_push    = hit_live & (~fifo_full | do_pop);
    do_drop    = hit_live & fifo_full & ~do_pop;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    hit_cnt_d  = hit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;

    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      hit_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      if (hit_live && (hit_cnt_q != '1)) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
      if (do_drop && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      ovf_d = ovf_q | do_drop;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hit_cnt_q  <= hit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage is not reset; unoccupied slots are never presented because
  // the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_ts_q[wr_ptr_q] <= ts_q;
    end
  end

`ifdef SEQ_EVENT_LOGGER_GAP_EN
  // Cycles since the last stored hit, saturating at all-ones. Holding it at
  // all-ones after reset/clear makes the first stored hit report all-ones,
  // and saturation covers true gaps of 2^TS_W or more.
  logic [TS_W-1:0] since_q, since_d;
  logic [TS_W-1:0] mem_gap_q [FIFO_DEPTH];

  always_comb begin
    since_d = since_q;
    if (clr_i) begin
      since_d = '1;
    end else if (do_push) begin
      // The next edge is one cycle after this stored hit.
      since_d = TS_W'(1);
    end else if (since_q != '1) begin
      since_d = since_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      since_q <= '1;
    end else begin
      since_q <= since_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_gap_q[wr_ptr_q] <= since_q;
    end
  end

  always_comb begin
    evt_gap = fifo_empty ? '0 : mem_gap_q[rd_ptr_q];
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_valid  = ~fifo_empty;
    evt_ts     = fifo_empty ? '0 : mem_ts_q[rd_ptr_q];
    fifo_level = level_q;
    hit_count  = hit_cnt_q;
    drop_count = drop_cnt_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench for seq_event_logger. A table of per-edge vectors covers
// reset, single hits, FIFO fill/overflow/drain, simultaneous push+pop when full
// and clear priority; hand-written sequences cover counter saturation
// (CNT_W=2 instance) and, when SEQ_EVENT_LOGGER_GAP_EN is defined, the gap
// output including saturation on a TS_W=4 instance.

module tb_seq_event_logger;

  logic        clk = 1'b0;
  logic        reset, hit, clr, rdy;
  logic        dut_valid, dut_ovf;
  logic [15:0] dut_ts;
  logic [2:0]  dut_level;
  logic [7:0]  dut_hits, dut_drops;

  logic        sat_hit, sat_clr, sat_rdy, sat_valid, sat_ovf;
  logic [15:0] sat_ts;
  logic [2:0]  sat_level;
  logic [1:0]  sat_hits, sat_drops;

  always #5 clk = ~clk;

`ifdef SEQ_EVENT_LOGGER_GAP_EN
  logic [15:0] dut_gap;
  logic        g4_hit, g4_clr, g4_rdy, g4_valid, g4_ovf;
  logic [3:0]  g4_ts, g4_gap;
  logic [2:0]  g4_level;
  logic [7:0]  g4_hits, g4_drops;
`endif

  seq_event_logger u_dut (
    .clk        (clk),
    .reset      (reset),
    .hit_i      (hit),
    .clr_i      (clr),
    .evt_valid  (dut_valid),
    .evt_ready  (rdy),
    .evt_ts     (dut_ts),
    .fifo_level (dut_level),
    .hit_count  (dut_hits),
    .drop_count (dut_drops),
    .overflow   (dut_ovf)
`ifdef SEQ_EVENT_LOGGER_GAP_EN
    ,
    .evt_gap    (dut_gap)
`endif
  );

  seq_event_logger #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .hit_i      (sat_hit),
    .clr_i      (sat_clr),
    .evt_valid  (sat_valid),
    .evt_ready  (sat_rdy),
    .evt_ts     (sat_ts),
    .fifo_level (sat_level),
    .hit_count  (sat_hits),
    .drop_count (sat_drops),
    .overflow   (sat_ovf)
`ifdef SEQ_EVENT_LOGGER_GAP_EN
    ,
    .evt_gap    ()
`endif
  );

`ifdef SEQ_EVENT_LOGGER_GAP_EN
  seq_event_logger #(.TS_W(4)) u_g4 (
    .clk        (clk),
    .reset      (reset),
    .hit_i      (g4_hit),
    .clr_i      (g4_clr),
    .evt_valid  (g4_valid),
    .evt_ready  (g4_rdy),
    .evt_ts     (g4_ts),
    .fifo_level (g4_level),
    .hit_count  (g4_hits),
    .drop_count (g4_drops),
    .overflow   (g4_ovf),
    .evt_gap    (g4_gap)
  );
`endif

  typedef struct {
    bit          rst, hit, clr, rdy;
    bit          v;
    int unsigned ts, lvl, hits, drops;
    bit          ovf;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit rst_v, bit hit_v, bit clr_v, bit rdy_v, bit v,
                              int unsigned ts, int unsigned lvl, int unsigned hits,
                              int unsigned drops, bit ovf);
    vec_t r;
    r.rst = rst_v; r.hit = hit_v; r.clr = clr_v; r.rdy = rdy_v;
    r.v = v; r.ts = ts; r.lvl = lvl; r.hits = hits; r.drops = drops; r.ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled one falling edge later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; hit = 1'b0; clr = 1'b0; rdy = 1'b0;
    sat_hit = 1'b0; sat_clr = 1'b0; sat_rdy = 1'b0;
`ifdef SEQ_EVENT_LOGGER_GAP_EN
    g4_hit = 1'b0; g4_clr = 1'b0; g4_rdy = 1'b0;
`endif

    //                 rst hit clr rdy | v  ts lvl hits drops ovf   (comment: ts at edge)
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // reset
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t0
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t1
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t2
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t3
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t4
    vq.push_back(mk(0, 1, 0, 0, 1,  5, 1,  1, 0, 0));  // t5 hit
    vq.push_back(mk(0, 0, 0, 0, 1,  5, 1,  1, 0, 0));  // t6 head held
    vq.push_back(mk(0, 0, 0, 1, 0,  0, 0,  1, 0, 0));  // t7 pop
    vq.push_back(mk(0, 1, 0, 1, 1,  8, 1,  2, 0, 0));  // t8 push on empty+ready
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // reset discards entry
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t0
    vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0));  // t1
    vq.push_back(mk(0, 1, 0, 0, 1,  2, 1,  1, 0, 0));  // t2
    vq.push_back(mk(0, 0, 0, 0, 1,  2, 1,  1, 0, 0));  // t3
    vq.push_back(mk(0, 1, 0, 0, 1,  2, 2,  2, 0, 0));  // t4
    vq.push_back(mk(0, 0, 0, 0, 1,  2, 2,  2, 0, 0));  // t5
    vq.push_back(mk(0, 1, 0, 0, 1,  2, 3,  3, 0, 0));  // t6
    vq.push_back(mk(0, 0, 0, 0, 1,  2, 3,  3, 0, 0));  // t7
    vq.push_back(mk(0, 1, 0, 0, 1,  2, 4,  4, 0, 0));  // t8 full
    vq.push_back(mk(0, 0, 0, 0, 1,  2, 4,  4, 0, 0));  // t9
    vq.push_back(mk(0, 1, 0, 0, 1,  2, 4,  5, 1, 1));  // t10 dropped
    vq.push_back(mk(0, 0, 0, 1, 1,  4, 3,  5, 1, 1));  // t11
    vq.push_back(mk(0, 0, 0, 1, 1,  6, 2,  5, 1, 1));  // t12
    vq.push_back(mk(0, 0, 0, 1, 1,  8, 1,  5, 1, 1));  // t13
    vq.push_back(mk(0, 0, 0, 1, 0,  0, 0,  5, 1, 1));  // t14 empty
    vq.push_back(mk(0, 1, 0, 0, 1, 15, 1,  6, 1, 1));  // t15
    vq.push_back(mk(0, 1, 0, 0, 1, 15, 2,  7, 1, 1));  // t16
    vq.push_back(mk(0, 1, 0, 0, 1, 15, 3,  8, 1, 1));  // t17
    vq.push_back(mk(0, 1, 0, 0, 1, 15, 4,  9, 1, 1));  // t18 full
    vq.push_back(mk(0, 1, 0, 1, 1, 16, 4, 10, 1, 1));  // t19 push+pop when full
    vq.push_back(mk(0, 0, 0, 1, 1, 17, 3, 10, 1, 1));  // t20
    vq.push_back(mk(0, 0, 0, 1, 1, 18, 2, 10, 1, 1));  // t21
    vq.push_back(mk(0, 0, 0, 1, 1, 19, 1, 10, 1, 1));  // t22 new tail
    vq.push_back(mk(0, 0, 0, 1, 0,  0, 0, 10, 1, 1));  // t23
    vq.push_back(mk(0, 1, 0, 0, 1, 24, 1, 11, 1, 1));  // t24
    vq.push_back(mk(0, 1, 0, 0, 1, 24, 2, 12, 1, 1));  // t25
    vq.push_back(mk(0, 1, 0, 0, 1, 24, 3, 13, 1, 1));  // t26
    vq.push_back(mk(0, 1, 1, 1, 0,  0, 0,  0, 0, 0));  // t27 clear wins
    vq.push_back(mk(0, 1, 0, 0, 1, 28, 1,  1, 0, 0));  // t28 ts kept counting
    vq.push_back(mk(0, 0, 0, 1, 0,  0, 0,  1, 0, 0));  // t29

    @(negedge clk);
    foreach (vq[i]) begin
      reset = vq[i].rst; hit = vq[i].hit; clr = vq[i].clr; rdy = vq[i].rdy;
      tick();
      chk("evt_valid",  i, 32'(dut_valid), 32'(vq[i].v));
      chk("evt_ts",     i, 32'(dut_ts),    vq[i].ts);
      chk("fifo_level", i, 32'(dut_level), vq[i].lvl);
      chk("hit_count",  i, 32'(dut_hits),  vq[i].hits);
      chk("drop_count", i, 32'(dut_drops), vq[i].drops);
      chk("overflow",   i, 32'(dut_ovf),   32'(vq[i].ovf));
    end
    hit = 1'b0; clr = 1'b0; rdy = 1'b0;

    // Saturation on a CNT_W=2 instance with the consumer always ready.
    reset = 1'b1;
    tick();
    reset = 1'b0; sat_hit = 1'b1; sat_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_hit_count",  k, 32'(sat_hits),  (k < 3) ? k + 1 : 3);
      chk("sat_drop_count", k, 32'(sat_drops), 0);
      chk("sat_fifo_level", k, 32'(sat_level), 1);
    end
    sat_hit = 1'b0; sat_rdy = 1'b0;

`ifdef SEQ_EVENT_LOGGER_GAP_EN
    // Gap: u_dut hits at ts 3,10,11; u_g4 (TS_W=4) hits at ts 1 and 18 (wraps to 2).
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t <= 18; t++) begin
      hit    = (t == 3) || (t == 10) || (t == 11);
      g4_hit = (t == 1) || (t == 18);
      tick();
    end
    hit = 1'b0; g4_hit = 1'b0;
    chk("gap_level",   0, 32'(dut_level), 3);
    chk("gap_ts",      0, 32'(dut_ts),    3);
    chk("gap_first",   0, 32'(dut_gap),   32'h0000_ffff);
    chk("g4_level",    0, 32'(g4_level),  2);
    chk("g4_ts",       0, 32'(g4_ts),     1);
    chk("g4_gap",      0, 32'(g4_gap),    15);
    rdy = 1'b1; g4_rdy = 1'b1;
    tick();
    rdy = 1'b0; g4_rdy = 1'b0;
    chk("gap_ts",      1, 32'(dut_ts),    10);
    chk("gap_second",  1, 32'(dut_gap),   7);
    chk("g4_ts",       1, 32'(g4_ts),     2);
    chk("g4_gap_sat",  1, 32'(g4_gap),    15);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("gap_ts",      2, 32'(dut_ts),    11);
    chk("gap_third",   2, 32'(dut_gap),   1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("gap_valid",   3, 32'(dut_valid), 0);
    chk("gap_empty",   3, 32'(dut_gap),   0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
